counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
- Run/direction controller for the board's up/down binary counter.
- Turns single-cycle button requests (already debounced and edge-detected upstream) into the counter's hold and direction controls.
- Paces counting with an internal prescaler and optionally ping-pongs between 0 and the maximum count.
- Sits between the button conditioning logic and the counter; the counter's count feeds back into this block for endpoint detection.

Parameters:
- WIDTH, 3: width of the counter being sequenced. Max count MAX = 2**WIDTH-1.
- DIV, 2: counter advances once every DIV clocks while running. Legal range DIV >= 1; DIV=1 means every clock.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- up_req_i  input  1  request to count up (one-cycle pulse).
- down_req_i  input  1  request to count down (one-cycle pulse).
- stop_req_i  input  1  request to stop (one-cycle pulse).
- pingpong_i  input  1  level; 1 = reverse direction at the endpoints instead of wrapping.
- count_i  input  WIDTH  current counter value (feedback).
- hold_o  output  1  to the counter enable_i. 1 = counter holds; 0 = counter advances on this edge.
- dir_o  output  1  to the counter dir_i. 0 = up, 1 = down.
- tick_o  output  1  prescaler tick, high one cycle per DIV clocks while running.
- state_o  output  2  current state: 00 STOPPED, 01 UP, 10 DOWN.

Behaviour:
- All registers reset synchronously on rst=1.
  - After the reset edge: state=STOPPED, dir register=0, prescaler div_cnt=0.
  - Outputs after reset: hold_o=1, dir_o=0, tick_o=0, state_o=00.
- rst has priority over every request.
- Requests are sampled every clock. Priority: stop_req_i > (up_req_i XOR down_req_i).
  - up_req_i and down_req_i both high with no stop: the request is ignored and the state is unchanged.
- State transitions:
  - From any state, stop -> STOPPED.
  - up only -> UP.
  - down only -> DOWN.
  - A request for the current state is a no-op.
- Prescaler (div_cnt, ceil(log2(DIV))+1 bits):
  - Counts 0..DIV-1 only in UP/DOWN.
  - Clears to 0 on entry to STOPPED and on STOPPED->UP/DOWN.
  - An UP<->DOWN change does not clear it.
- tick_o = running AND div_cnt == DIV-1. It is combinational from registered state.
- Direction register:
  - Loads 0 on entry to UP and 1 on entry to DOWN.
  - Holds its value in STOPPED, so dir_o keeps the last running direction.
  - dir_o = direction register.
- turnaround = pingpong_i AND ((UP AND count_i==MAX) OR (DOWN AND count_i==0)).
- hold_o = NOT (tick_o AND NOT turnaround).
- On a turnaround cycle (any cycle, tick or not, with no stop/up/down request):
  - Next state is the opposite direction.
  - The counter holds on that edge.
  - The endpoint value is therefore held for at least one extra cycle.
  - A request in the same cycle overrides the turnaround.
- Wrap-around with pingpong_i=0 is performed by the counter itself: 7->0 up, 0->7 down. This block does not intervene.
- Latency: a request pulse in cycle N changes state_o at edge N. The first advance occurs on the DIV-th edge after that.
- Reset mid-run: everything returns to the reset values. No pending tick survives.

Optional Feature:
- Macro COUNTER_SEQUENCER_STEP_EN.
- Defined:
  - Adds port step_req_i (input, 1).
  - In STOPPED, a step pulse in cycle N sets a step_pending flop at edge N.
  - In cycle N+1, hold_o=0 for exactly one cycle, so the counter moves one position in direction dir_o. The flop then clears.
  - Pingpong endpoint rules do not apply to steps.
  - step_req_i is ignored outside STOPPED and on any cycle with another request.
  - A stop request clears step_pending.
- Undefined: the port does not exist and there is no step logic.

Test Plan:
- Reset: assert rst for 2 cycles from a running state -> state_o=00, hold_o=1, dir_o=0, tick_o=0. Counter at 0.
- Up counting, WIDTH=3, DIV=2, pingpong=0: up pulse at count 0 -> tick_o every 2nd cycle. Count steps 1..7 then 0 after 16 clocks, with hold_o low only on tick cycles.
- Ping-pong, DIV=1: start UP at 0 -> counts 0..7, holds 7 one extra cycle with state_o 01->10, then 6..0, holds 0, then back to UP (state_o=01).
- Simultaneous requests: in DOWN, pulse up and down together -> state stays 10. Pulse stop and up together -> STOPPED, count frozen for 10 cycles, dir_o stays 1.
- Reset mid-run: DOWN at count 5 with div_cnt=1, assert rst -> state 00, count 0, next up pulse gives the first advance exactly DIV edges later.
- With COUNTER_SEQUENCER_STEP_EN: in STOPPED, dir=0, count=3, pulse step -> hold_o=0 for one cycle, count=4, then held. A step pulse while UP -> no extra advance.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Run/direction controller for an up/down binary counter. Converts
//   one-cycle button requests into the counter's hold/direction controls,
//   paces advances with an internal prescaler and, optionally, ping-pongs
//   between 0 and MAX instead of wrapping.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   up_req_i    one-cycle request to count up
//   down_req_i  one-cycle request to count down
//   stop_req_i  one-cycle request to stop (highest priority)
//   step_req_i  one-cycle single-step request (COUNTER_SEQUENCER_STEP_EN only)
//   pingpong_i  level; 1 = reverse at the endpoints instead of wrapping
//   count_i     counter value fed back for endpoint detection
//   hold_o      1 = counter holds, 0 = counter advances on this edge
//   dir_o       0 = up, 1 = down
//   tick_o      prescaler tick, one cycle per DIV clocks while running
//   state_o     00 STOPPED, 01 UP, 10 DOWN
//
// Build option:
//   COUNTER_SEQUENCER_STEP_EN  adds step_req_i and single-step logic.
//
// state   | meaning
// --------+-----------------------------------------------
// STOPPED | counter held; dir keeps last running direction
// UP      | advancing upward once per DIV clocks
// DOWN    | advancing downward once per DIV clocks

module counter_sequencer #(
  parameter int WIDTH = 3,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_req_i,
  input  logic             down_req_i,
  input  logic             stop_req_i,
`ifdef COUNTER_SEQUENCER_STEP_EN
  input  logic             step_req_i,
`endif
  input  logic             pingpong_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             hold_o,
  output logic             dir_o,
  output logic             tick_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] S_STOPPED = 2'b00;
  localparam logic [1:0] S_UP      = 2'b01;
  localparam logic [1:0] S_DOWN    = 2'b10;

  localparam int             DW     = $clog2(DIV) + 1;
  localparam logic [DW-1:0]  DIV_M1 = DW'(DIV - 1);
  localparam logic [WIDTH-1:0] MAX  = '1;

  logic [1:0]    r_state;
  logic          r_dir;
  logic [DW-1:0] r_div_cnt;

  logic [1:0]    w_next;
  logic          w_running;
  logic          w_tick;
  logic          w_turn;
  logic          w_step_adv;

  assign w_running = (r_state == S_UP) || (r_state == S_DOWN);
  assign w_tick    = w_running && (r_div_cnt == DIV_M1);
  assign w_turn    = pingpong_i &&
                     (((r_state == S_UP)   && (count_i == MAX)) ||
                      ((r_state == S_DOWN) && (count_i == '0)));

  // Requests override a pending turnaround; up+down together cancel out.
  always_comb begin
    w_next = r_state;
    if (stop_req_i)
      w_next = S_STOPPED;
    else if (up_req_i && !down_req_i)
      w_next = S_UP;
    else if (down_req_i && !up_req_i)
      w_next = S_DOWN;
    else if (w_turn)
      w_next = (r_state == S_UP) ? S_DOWN : S_UP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_STOPPED;
    end else begin
      r_state <= w_next;
    end
  end

  // Cleared on any transition into or out of STOPPED; an UP<->DOWN change
  // keeps the phase so the pacing stays regular across a turnaround.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if ((w_next == S_STOPPED) || (r_state == S_STOPPED)) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_M1) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir <= 1'b0;
    end else if (w_next == S_UP) begin
      r_dir <= 1'b0;
    end else if (w_next == S_DOWN) begin
      r_dir <= 1'b1;
    end
  end

`ifdef COUNTER_SEQUENCER_STEP_EN
  logic r_step_pending;
  logic w_step_accept;

  // Only a lone step in STOPPED is accepted; a stop (or any other request)
  // in the same cycle leaves the flop cleared.
  assign w_step_accept = (r_state == S_STOPPED) && step_req_i &&
                         !stop_req_i && !up_req_i && !down_req_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_pending <= 1'b0;
    end else begin
      r_step_pending <= w_step_accept;
    end
  end

  assign w_step_adv = r_step_pending;
`else
  assign w_step_adv = 1'b0;
`endif

  // Turnaround suppresses the advance so the endpoint is held an extra cycle.
  assign hold_o  = !((w_tick && !w_turn) || w_step_adv);
  assign dir_o   = r_dir;
  assign tick_o  = w_tick;
  assign state_o = r_state;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Directed bench for counter_sequencer. Two instances share the request
//   inputs: dut (DIV=2) and dut1 (DIV=1, used for ping-pong). Each drives a
//   simple behavioural up/down counter that feeds count_i back.

module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_req, down_req, stop_req, pingpong;
`ifdef COUNTER_SEQUENCER_STEP_EN
  logic       step_req;
`endif
  logic [2:0] cnt, cnt1;
  logic       hold, dir, tick, hold1, dir1, tick1;
  logic [1:0] state, state1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(3), .DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_req_i   (up_req),
    .down_req_i (down_req),
    .stop_req_i (stop_req),
`ifdef COUNTER_SEQUENCER_STEP_EN
    .step_req_i (step_req),
`endif
    .pingpong_i (pingpong),
    .count_i    (cnt),
    .hold_o     (hold),
    .dir_o      (dir),
    .tick_o     (tick),
    .state_o    (state)
  );

  counter_sequencer #(.WIDTH(3), .DIV(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .up_req_i   (up_req),
    .down_req_i (down_req),
    .stop_req_i (stop_req),
`ifdef COUNTER_SEQUENCER_STEP_EN
    .step_req_i (1'b0),
`endif
    .pingpong_i (pingpong),
    .count_i    (cnt1),
    .hold_o     (hold1),
    .dir_o      (dir1),
    .tick_o     (tick1),
    .state_o    (state1)
  );

  // Behavioural counters: advance when hold is low, wrap naturally in 3 bits.
  always @(posedge clk) begin
    if (rst) cnt <= 3'd0;
    else if (!hold) cnt <= dir ? cnt - 3'd1 : cnt + 3'd1;
  end

  always @(posedge clk) begin
    if (rst) cnt1 <= 3'd0;
    else if (!hold1) cnt1 <= dir1 ? cnt1 - 3'd1 : cnt1 + 3'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic u, input logic d, input logic s);
    up_req = u; down_req = d; stop_req = s;
    cyc();
    up_req = 1'b0; down_req = 1'b0; stop_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  int pp_cnt [17] = '{1,2,3,4,5,6,7,7,6,5,4,3,2,1,0,0,1};
  int pp_st  [17] = '{1,1,1,1,1,1,1,2,2,2,2,2,2,2,2,1,1};

  initial begin
    rst = 1'b1; up_req = 1'b0; down_req = 1'b0; stop_req = 1'b0; pingpong = 1'b0;
`ifdef COUNTER_SEQUENCER_STEP_EN
    step_req = 1'b0;
`endif
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_hold",  hold,  1);
    chk("rst_dir",   dir,   0);
    chk("rst_tick",  tick,  0);
    chk("rst_cnt",   cnt,   0);

    // Up counting, DIV=2: after edge N+k, tick = k odd, count = k/2 mod 8.
    pulse(1'b1, 1'b0, 1'b0);
    chk("up_state", state, 1);
    chk("up_tick0", tick, 0);
    chk("up_hold0", hold, 1);
    chk("up_cnt0",  cnt,  0);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk($sformatf("up_tick_%0d", k), tick, k % 2);
      chk($sformatf("up_hold_%0d", k), hold, (k % 2) == 0);
      chk($sformatf("up_cnt_%0d",  k), cnt,  (k / 2) % 8);
    end

    // Ping-pong on the DIV=1 instance.
    do_reset();
    pingpong = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    chk("pp_state0", state1, 1);
    chk("pp_cnt0",   cnt1,   0);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      chk($sformatf("pp_cnt_%0d",   k), cnt1,   pp_cnt[k-1]);
      chk($sformatf("pp_state_%0d", k), state1, pp_st[k-1]);
      if (k == 7 || k == 15) chk($sformatf("pp_turn_hold_%0d", k), hold1, 1);
      if (k == 8) chk("pp_dir_down", dir1, 1);
      if (k == 16) chk("pp_dir_up", dir1, 0);
    end
    pingpong = 1'b0;

    // Simultaneous requests on the DIV=2 instance.
    do_reset();
    pulse(1'b0, 1'b1, 1'b0);
    chk("sim_down_state", state, 2);
    cyc(); cyc(); cyc();
    chk("sim_cnt_k3", cnt, 7);
    pulse(1'b1, 1'b1, 1'b0);
    chk("sim_updown_state", state, 2);
    chk("sim_updown_cnt",   cnt,   6);
    pulse(1'b1, 1'b0, 1'b1);
    chk("sim_stopup_state", state, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk($sformatf("sim_frozen_cnt_%0d", k), cnt, 6);
      chk($sformatf("sim_frozen_hold_%0d", k), hold, 1);
    end
    chk("sim_dir_kept", dir,   1);
    chk("sim_tick",     tick,  0);
    chk("sim_state",    state, 0);

    // Reset mid-run: DOWN at 5 with div_cnt=1, then reset.
    pulse(1'b0, 1'b1, 1'b0);
    cyc(); cyc(); cyc();
    chk("mid_cnt5",  cnt,  5);
    chk("mid_tick",  tick, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_cnt",   cnt,   0);
    chk("mid_rst_tick",  tick,  0);
    chk("mid_rst_dir",   dir,   0);
    chk("mid_rst_hold",  hold,  1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("mid_up_hold0", hold, 1);
    cyc();
    chk("mid_cnt_p1", cnt, 0);
    chk("mid_tick_p1", tick, 1);
    cyc();
    chk("mid_cnt_p2", cnt, 1);

`ifdef COUNTER_SEQUENCER_STEP_EN
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) cyc();
    chk("stp_cnt3", cnt, 3);
    pulse(1'b0, 1'b0, 1'b1);
    chk("stp_stopped", state, 0);
    chk("stp_cnt3b",   cnt,   3);
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    chk("stp_hold_low", hold, 0);
    chk("stp_cnt_pre",  cnt,  3);
    cyc();
    chk("stp_cnt4",    cnt,  4);
    chk("stp_hold_hi", hold, 1);
    cyc();
    chk("stp_cnt4_held", cnt, 4);
    pulse(1'b1, 1'b0, 1'b0);
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    chk("stp_run_cnt_u1",  cnt,  4);
    chk("stp_run_hold_u1", hold, 0);
    cyc();
    chk("stp_run_cnt_u2",  cnt,  5);
    chk("stp_run_hold_u2", hold, 1);
    cyc();
    chk("stp_run_cnt_u3",  cnt,  5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
